// File: rtl/iserdes_gen.sv
// iserdes_gen: multi-lane serial-to-parallel deserialiser with bitslip; auto-align FSM under ISERDES_GEN_AUTOALIGN_EN.
// Latency: Q/Q_VALID register one cycle after the completing bit.
// Backpressure: none; CE paces the serial input and Q holds between Q_VALID strobes.
module iserdes_gen #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    NUM_CH        = 1,
  parameter bit                    MSB_FIRST     = 1,
  parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 'h5C
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         CE,
  input  logic                         BITSLIP,
  input  logic [NUM_CH-1:0]            D,
  output logic [NUM_CH*DATA_WIDTH-1:0] Q,
  output logic                         Q_VALID,
  input  logic                         ALIGN_REQ,
  output logic                         ALIGNED,
  output logic                         ALIGN_FAIL
);

  localparam int            CW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [NUM_CH*DATA_WIDTH-1:0] sr;
  logic [NUM_CH*DATA_WIDTH-1:0] sr_nxt;
  logic [CW-1:0]                cnt;
  logic                         slip_req;
  logic                         word_done;

  always_comb begin
    sr_nxt = sr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (MSB_FIRST)
        sr_nxt[c*DATA_WIDTH +: DATA_WIDTH] = {sr[c*DATA_WIDTH +: DATA_WIDTH-1], D[c]};
      else
        sr_nxt[c*DATA_WIDTH +: DATA_WIDTH] = {D[c], sr[c*DATA_WIDTH+1 +: DATA_WIDTH-1]};
    end
  end

  // A slip still shifts the bit in; holding the counter pushes the boundary one bit later.
  assign word_done = CE & ~slip_req & (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr      <= '0;
      cnt     <= '0;
      Q       <= '0;
      Q_VALID <= 1'b0;
    end else begin
      Q_VALID <= word_done;
      if (CE) begin
        sr <= sr_nxt;
        if (!slip_req)
          cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        if (word_done)
          Q <= sr_nxt;
      end
    end
  end

`ifdef ISERDES_GEN_AUTOALIGN_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
  } state_t;

  state_t      state;
  logic [CW:0] slip_cnt;
  logic        disc_cnt;
  logic        manual_ok;

  // Manual slips would corrupt the search, so they are locked out while it runs.
  assign manual_ok = (state != ST_CHECK) && (state != ST_SLIP) && (state != ST_WAIT);
  assign slip_req  = (BITSLIP & manual_ok) | (state == ST_SLIP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      slip_cnt   <= '0;
      disc_cnt   <= 1'b0;
      ALIGNED    <= 1'b0;
      ALIGN_FAIL <= 1'b0;
    end else if (ALIGN_REQ) begin
      state      <= ST_CHECK;
      slip_cnt   <= '0;
      disc_cnt   <= 1'b0;
      ALIGNED    <= 1'b0;
      ALIGN_FAIL <= 1'b0;
    end else begin
      case (state)
        ST_CHECK: if (Q_VALID) begin
          if (Q[DATA_WIDTH-1:0] == TRAIN_PATTERN) begin
            state   <= ST_LOCKED;
            ALIGNED <= 1'b1;
          end else if (slip_cnt == (CW+1)'(DATA_WIDTH)) begin
            state      <= ST_FAIL;
            ALIGN_FAIL <= 1'b1;
          end else begin
            state <= ST_SLIP;
          end
        end
        ST_SLIP: if (CE) begin
          slip_cnt <= slip_cnt + (CW+1)'(1);
          disc_cnt <= 1'b0;
          state    <= ST_WAIT;
        end
        // Two words are dropped so the compared word is fully past the slip.
        ST_WAIT: if (Q_VALID) begin
          if (disc_cnt)
            state <= ST_CHECK;
          else
            disc_cnt <= 1'b1;
        end
        default: state <= state;
      endcase
    end
  end
`else
  logic unused_align_req;
  assign unused_align_req = ALIGN_REQ;
  assign slip_req         = BITSLIP;
  assign ALIGNED          = 1'b0;
  assign ALIGN_FAIL       = 1'b0;
`endif

endmodule

// File: tb/tb_iserdes_gen.sv
// Directed bench for iserdes_gen: single-lane, 4-lane and LSB-first instances with a word scoreboard.
module tb_iserdes_gen;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE = 1'b0;
  logic        BITSLIP = 1'b0;
  logic        ALIGN_REQ = 1'b0;
  logic        d1 = 1'b0;
  logic [3:0]  d4 = 4'h0;

  logic [7:0]  q1;
  logic        qv1, al1, af1;
  logic [31:0] q4;
  logic        qv4, al4, af4;
  logic [7:0]  ql;
  logic        qvl, all_l, afl;

  always #5 CLK = ~CLK;

  iserdes_gen #(.DATA_WIDTH(8), .NUM_CH(1), .MSB_FIRST(1), .TRAIN_PATTERN(8'h5C)) u_dut (
    .CLK(CLK), .RST(RST), .CE(CE), .BITSLIP(BITSLIP), .D(d1), .Q(q1), .Q_VALID(qv1),
    .ALIGN_REQ(ALIGN_REQ), .ALIGNED(al1), .ALIGN_FAIL(af1));

  iserdes_gen #(.DATA_WIDTH(8), .NUM_CH(4), .MSB_FIRST(1), .TRAIN_PATTERN(8'h5C)) u_dut4 (
    .CLK(CLK), .RST(RST), .CE(CE), .BITSLIP(BITSLIP), .D(d4), .Q(q4), .Q_VALID(qv4),
    .ALIGN_REQ(ALIGN_REQ), .ALIGNED(al4), .ALIGN_FAIL(af4));

  iserdes_gen #(.DATA_WIDTH(8), .NUM_CH(1), .MSB_FIRST(0), .TRAIN_PATTERN(8'h5C)) u_lsb (
    .CLK(CLK), .RST(RST), .CE(CE), .BITSLIP(BITSLIP), .D(d4[0]), .Q(ql), .Q_VALID(qvl),
    .ALIGN_REQ(ALIGN_REQ), .ALIGNED(all_l), .ALIGN_FAIL(afl));

  int         n_cmp = 0;
  int         n_bad = 0;
  int         qv_cnt = 0;
  bit         sb_en = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic [7:0] cur_pat = 8'hA5;
  int         cur_off = 0;
  int         sidx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at a falling edge, return at the next falling edge.
  task automatic step(input logic dv, input logic [3:0] d4v, input logic ce, input logic bs);
    d1 = dv; d4 = d4v; CE = ce; BITSLIP = bs;
    @(negedge CLK);
  endtask

  function automatic logic pbit(input logic [7:0] p, input int i);
    return p[7 - (i % 8)];
  endfunction

  task automatic feed(input int n, input logic bs);
    for (int k = 0; k < n; k++) begin
      step(pbit(cur_pat, sidx + cur_off), 4'h0, 1'b1, bs);
      sidx++;
    end
  endtask

  // Runs the stream on until a word has just completed, so the next 8 bits form one word.
  task automatic sync_word(input string tag);
    int k = 0;
    while (qv1 !== 1'b1 && k < 20) begin
      feed(1, 1'b0);
      k++;
    end
    check({tag, "_sync"}, {31'h0, qv1}, 32'h1);
  endtask

  task automatic sb_words(input logic [7:0] w, input int n);
    sb_en = 1'b1;
    for (int k = 0; k < n; k++) exp_q.push_back(w);
    feed(8 * n, 1'b0);
    sb_en = 1'b0;
  endtask

  task automatic slips(input int n);
    for (int k = 0; k < n; k++) begin
      feed(1, 1'b1);
      feed(1, 1'b0);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    if (!RST && qv1) begin
      qv_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {24'h0, q1}, 32'h0 - 32'h1);
        end else begin
          mon_exp = exp_q.pop_front();
          check("sb_word", {24'h0, q1}, {24'h0, mon_exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] l0, l1, l2, l3;
    int k;
    l0 = 8'h01; l1 = 8'h80; l2 = 8'hFF; l3 = 8'h3C;

    @(negedge CLK);
    @(negedge CLK);
    check("rst_q", {24'h0, q1}, 32'h0);
    check("rst_qv", {31'h0, qv1}, 32'h0);
    check("rst_aligned", {31'h0, al1}, 32'h0);
    check("rst_align_fail", {31'h0, af1}, 32'h0);
    check("rst_q4", q4, 32'h0);
    RST = 1'b0;

    // 0xA5 on the main lane, four distinct bytes on the 4-lane instance.
    sidx = 0;
    exp_q.push_back(8'hA5);
    sb_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      step(pbit(8'hA5, b), {l3[7-b], l2[7-b], l1[7-b], l0[7-b]}, 1'b1, 1'b0);
      if (b == 6) check("qv_before_8th", {31'h0, qv1}, 32'h0);
    end
    check("qv_latency", {31'h0, qv1}, 32'h1);
    check("q_a5", {24'h0, q1}, 32'hA5);
    check("q4_lanes", q4, 32'h3CFF8001);
    check("q4_qv", {31'h0, qv4}, 32'h1);
    check("lsb_first_q", {24'h0, ql}, 32'h80);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("qv_one_cycle", {31'h0, qv1}, 32'h0);
    check("q_hold", {24'h0, q1}, 32'hA5);
    sb_en = 1'b0;

    // CE low every other cycle.
    qv_cnt = 0;
    exp_q.push_back(8'hA5);
    sb_en = 1'b1;
    for (int b = 0; b < 8; b++) begin
      step(pbit(8'hA5, b), 4'h0, 1'b1, 1'b0);
      step(1'($urandom_range(0, 1)), 4'h0, 1'b0, 1'b1);
    end
    sb_en = 1'b0;
    check("ce_gap_qv_count", qv_cnt, 32'd1);
    check("ce_gap_q", {24'h0, q1}, 32'hA5);

    // Bitslip: 3 slips rotate the boundary, 8 in total wrap back.
    cur_pat = 8'hA5; cur_off = 0; sidx = 0;
    sb_words(8'hA5, 1);
    slips(3);
    sync_word("slip3");
    sb_words(8'h2D, 2);
    slips(5);
    sync_word("slip8");
    sb_words(8'hA5, 2);

`ifndef ISERDES_GEN_AUTOALIGN_EN
    ALIGN_REQ = 1'b1;
    feed(1, 1'b0);
    ALIGN_REQ = 1'b0;
    feed(8, 1'b0);
    check("noalign_aligned", {31'h0, al1}, 32'h0);
    check("noalign_fail", {31'h0, af1}, 32'h0);
`endif

    // Reset mid-word at counter 4.
    sync_word("pre_rst");
    feed(4, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("midrst_q", {24'h0, q1}, 32'h0);
    check("midrst_qv", {31'h0, qv1}, 32'h0);
    check("midrst_q4", q4, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    cur_pat = 8'h3C; sidx = 0; qv_cnt = 0;
    sb_en = 1'b1;
    exp_q.push_back(8'h3C);
    feed(7, 1'b0);
    check("postrst_no_early_word", qv_cnt, 32'd0);
    feed(1, 1'b0);
    check("postrst_qv", {31'h0, qv1}, 32'h1);
    sb_en = 1'b0;

`ifdef ISERDES_GEN_AUTOALIGN_EN
    // 0x5C pattern starting 5 bits after the current boundary; BITSLIP held must be ignored.
    cur_pat = 8'h5C; cur_off = 3; sidx = 0;
    ALIGN_REQ = 1'b1;
    feed(1, 1'b0);
    ALIGN_REQ = 1'b0;
    k = 0;
    while (al1 !== 1'b1 && k < 400) begin
      feed(1, 1'b1);
      k++;
    end
    check("align_locked", {31'h0, al1}, 32'h1);
    check("align_no_fail", {31'h0, af1}, 32'h0);
    check("align_q", {24'h0, q1}, 32'h5C);
    check("align_slips", 32'(u_dut.slip_cnt), 32'd5);
    sync_word("locked");
    sb_words(8'h5C, 2);

    cur_pat = 8'h00; cur_off = 0;
    ALIGN_REQ = 1'b1;
    feed(1, 1'b0);
    ALIGN_REQ = 1'b0;
    check("realign_clears_aligned", {31'h0, al1}, 32'h0);
    k = 0;
    while (af1 !== 1'b1 && k < 600) begin
      feed(1, 1'b0);
      k++;
    end
    check("align_fail", {31'h0, af1}, 32'h1);
    check("align_fail_not_locked", {31'h0, al1}, 32'h0);
    check("align_fail_slips", 32'(u_dut.slip_cnt), 32'd8);
    feed(20, 1'b0);
    check("fail_holds", {31'h0, af1}, 32'h1);
    ALIGN_REQ = 1'b1;
    feed(1, 1'b0);
    ALIGN_REQ = 1'b0;
    check("realign_clears_fail", {31'h0, af1}, 32'h0);
`endif

    feed(2, 1'b0);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
